// File: rtl/clock_adjust_ctrl_if.sv
// Button and display bundle between the time-setting controller and the clock datapath.
// Pulses (MODE, SELECT, tick, INC) are one clk cycle wide; ADJUST and sig2hz are levels.
interface clock_adjust_ctrl_if #(
  parameter int NFIELD = 3
);
  localparam int FW = $clog2(NFIELD);

  logic              tick;
  logic              sig2hz;
  logic              MODE;
  logic              SELECT;
  logic              ADJUST;
  logic [NFIELD-1:0] INC;
  logic [NFIELD-1:0] ON;
  logic              ADJMODE;
  logic [FW-1:0]     FIELD;

  modport master (
    output tick, sig2hz, MODE, SELECT, ADJUST,
    input  INC, ON, ADJMODE, FIELD
  );

  modport slave (
    input  tick, sig2hz, MODE, SELECT, ADJUST,
    output INC, ON, ADJMODE, FIELD
  );
endinterface

// File: rtl/clock_adjust_ctrl.sv
// Time-setting controller: NORM / ADJ(k) field selection, increment pulses, blink gate, timeout.
// Define CLKADJ_AUTOREPEAT_EN to build the hold-to-repeat logic; otherwise INC fires on presses only.
module clock_adjust_ctrl #(
  parameter int NFIELD      = 3,
  parameter int TIMEOUT     = 3000,
  parameter int REPEAT_DLY  = 50,
  parameter int REPEAT_RATE = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  clock_adjust_ctrl_if.slave   bus
);
  localparam int FW = $clog2(NFIELD);
  localparam int TW = $clog2(TIMEOUT + 1);

  if (NFIELD < 2 || TIMEOUT < 1 || REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("clock_adjust_ctrl: parameter out of range");
  end

  typedef enum logic {ST_NORM = 1'b0, ST_ADJ = 1'b1} mode_e;

  mode_e             mode_q, mode_d;
  logic [FW-1:0]     field_q, field_d;
  logic [NFIELD-1:0] inc_q, inc_d;
  logic              adj_q, adj_d;
  logic [TW-1:0]     to_q, to_d;

  logic in_adj;
  logic rise;
  logic timeout;
  logic hold_ok;
  logic repeat_fire;

  assign in_adj  = (mode_q == ST_ADJ);
  assign rise    = bus.ADJUST & ~adj_q;
  assign timeout = in_adj & ~bus.MODE & ~bus.SELECT & bus.tick & (to_q == TW'(TIMEOUT - 1));
  // The selected field survives this cycle: only then may it increment.
  assign hold_ok = in_adj & ~bus.MODE & ~bus.SELECT & ~timeout;

  always_comb begin
    mode_d  = mode_q;
    field_d = field_q;
    if (!in_adj) begin
      if (bus.MODE) begin
        mode_d  = ST_ADJ;
        field_d = '0;
      end
    end else if (bus.MODE || timeout) begin
      mode_d  = ST_NORM;
      field_d = '0;
    end else if (bus.SELECT) begin
      field_d = (field_q == FW'(NFIELD - 1)) ? '0 : field_q + 1'b1;
    end
  end

  // Entering adjust forgets the held button so a press already down counts as a rise.
  assign adj_d = (!in_adj && bus.MODE) ? 1'b0 : bus.ADJUST;

  always_comb begin
    to_d = to_q;
    if (!in_adj || bus.MODE || bus.SELECT || bus.ADJUST || timeout) begin
      to_d = '0;
    end else if (bus.tick) begin
      to_d = to_q + 1'b1;
    end
  end

`ifdef CLKADJ_AUTOREPEAT_EN
  localparam int RC_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RCW    = $clog2(RC_MAX + 1);

  typedef enum logic {PH_DELAY = 1'b0, PH_REPEAT = 1'b1} phase_e;

  phase_e           ph_q, ph_d;
  logic [RCW-1:0]   rc_q, rc_d;

  always_comb begin
    ph_d        = ph_q;
    rc_d        = rc_q;
    repeat_fire = 1'b0;
    if (!hold_ok || !bus.ADJUST || rise) begin
      ph_d = PH_DELAY;
      rc_d = '0;
    end else if (bus.tick) begin
      if ((ph_q == PH_DELAY  && rc_q == RCW'(REPEAT_DLY - 1)) ||
          (ph_q == PH_REPEAT && rc_q == RCW'(REPEAT_RATE - 1))) begin
        repeat_fire = 1'b1;
        ph_d        = PH_REPEAT;
        rc_d        = '0;
      end else begin
        rc_d = rc_q + 1'b1;
      end
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

  always_comb begin
    inc_d = '0;
    for (int i = 0; i < NFIELD; i++) begin
      inc_d[i] = hold_ok & (rise | repeat_fire) & (field_q == FW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= ST_NORM;
      field_q <= '0;
      inc_q   <= '0;
      adj_q   <= 1'b0;
      to_q    <= '0;
`ifdef CLKADJ_AUTOREPEAT_EN
      ph_q    <= PH_DELAY;
      rc_q    <= '0;
`endif
    end else begin
      mode_q  <= mode_d;
      field_q <= field_d;
      inc_q   <= inc_d;
      adj_q   <= adj_d;
      to_q    <= to_d;
`ifdef CLKADJ_AUTOREPEAT_EN
      ph_q    <= ph_d;
      rc_q    <= rc_d;
`endif
    end
  end

  // Blink gate follows the live ADJUST level so a held field stays lit.
  always_comb begin
    bus.ON = '1;
    for (int i = 0; i < NFIELD; i++) begin
      bus.ON[i] = ~(in_adj & (field_q == FW'(i)) & bus.sig2hz & ~bus.ADJUST);
    end
  end

  assign bus.INC     = inc_q;
  assign bus.ADJMODE = in_adj;
  assign bus.FIELD   = field_q;

endmodule

// File: tb/tb_clock_adjust_ctrl.sv
// Directed bench for clock_adjust_ctrl: vector table for mode/field/blink/press behaviour,
// plus hand sequences for reset, single press, auto-repeat and inactivity timeout.
module tb_clock_adjust_ctrl;
  localparam int NFIELD      = 3;
  localparam int TIMEOUT     = 3000;
  localparam int REPEAT_DLY  = 50;
  localparam int REPEAT_RATE = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  clock_adjust_ctrl_if #(.NFIELD(NFIELD)) bus ();

  clock_adjust_ctrl #(
    .NFIELD      (NFIELD),
    .TIMEOUT     (TIMEOUT),
    .REPEAT_DLY  (REPEAT_DLY),
    .REPEAT_RATE (REPEAT_RATE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       mode;
    logic       select;
    logic       adjust;
    logic       sig2hz;
    logic [2:0] inc;
    logic [2:0] on;
    logic       adjmode;
    logic [1:0] field;
  } vec_t;

  vec_t vecs[19];

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.MODE   = 1'b0;
    bus.SELECT = 1'b0;
    bus.tick   = 1'b0;
  endtask

  task automatic pulse_mode();
    bus.MODE = 1'b1;
    cycle();
    bus.MODE = 1'b0;
  endtask

  task automatic pulse_select();
    bus.SELECT = 1'b1;
    cycle();
    bus.SELECT = 1'b0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    idle();
    bus.ADJUST = 1'b0;
    bus.sig2hz = 1'b1;
    repeat (2) cycle();
    check("reset_inc",     32'(bus.INC),     32'h0);
    check("reset_on",      32'(bus.ON),      32'h7);
    check("reset_adjmode", 32'(bus.ADJMODE), 32'h0);
    check("reset_field",   32'(bus.FIELD),   32'h0);
    rst = 1'b0;
  endtask

  // Tick n times (one cycle high, one low) and count INC bits seen.
  task automatic run_ticks(input int n, output int pulses);
    pulses = 0;
    for (int t = 0; t < n; t++) begin
      bus.tick = 1'b1;
      cycle();
      pulses += $countones(bus.INC);
      bus.tick = 1'b0;
      cycle();
      pulses += $countones(bus.INC);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;

    //            mode  sel   adj   s2hz  inc     on      adjm  field
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b111, 1'b1, 2'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 3'b101, 1'b1, 2'd1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b101, 1'b1, 2'd1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 3'b111, 1'b1, 2'd1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b111, 1'b1, 2'd1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b101, 1'b1, 2'd1};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b111, 1'b1, 2'd2};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 3'b110, 1'b1, 2'd0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 3'b111, 1'b1, 2'd1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 3'b111, 1'b1, 2'd1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b101, 1'b1, 2'd1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 3'b111, 1'b1, 2'd1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b111, 1'b1, 2'd1};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 3'b111, 1'b0, 2'd0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b111, 1'b0, 2'd0};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 3'b111, 1'b1, 2'd0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 3'b111, 1'b1, 2'd0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b110, 1'b1, 2'd0};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 3'b111, 1'b0, 2'd0};

    do_reset();

    for (int v = 0; v < 19; v++) begin
      bus.MODE   = vecs[v].mode;
      bus.SELECT = vecs[v].select;
      bus.ADJUST = vecs[v].adjust;
      bus.sig2hz = vecs[v].sig2hz;
      bus.tick   = 1'b0;
      cycle();
      check($sformatf("vec%0d_inc", v),     32'(bus.INC),     32'(vecs[v].inc));
      check($sformatf("vec%0d_on", v),      32'(bus.ON),      32'(vecs[v].on));
      check($sformatf("vec%0d_adjmode", v), 32'(bus.ADJMODE), 32'(vecs[v].adjmode));
      check($sformatf("vec%0d_field", v),   32'(bus.FIELD),   32'(vecs[v].field));
    end
    idle();
    bus.ADJUST = 1'b0;
    cycle();

    // Reset in the middle of adjusting beats every other input.
    pulse_mode();
    pulse_select();
    check("pre_rst_field", 32'(bus.FIELD), 32'h1);
    rst        = 1'b1;
    bus.MODE   = 1'b1;
    bus.SELECT = 1'b1;
    bus.ADJUST = 1'b1;
    cycle();
    check("mid_rst_adjmode", 32'(bus.ADJMODE), 32'h0);
    check("mid_rst_field",   32'(bus.FIELD),   32'h0);
    check("mid_rst_inc",     32'(bus.INC),     32'h0);
    rst = 1'b0;
    idle();
    bus.ADJUST = 1'b0;
    cycle();

    // Single press in ADJ(2): one pulse, one cycle after the rise.
    do_reset();
    pulse_mode();
    pulse_select();
    pulse_select();
    check("single_field", 32'(bus.FIELD), 32'h2);
    bus.ADJUST = 1'b1;
    cycle();
    check("single_inc", 32'(bus.INC), 32'h4);
    run_ticks(3, pulses);
    bus.ADJUST = 1'b0;
    begin
      int more;
      run_ticks(2, more);
      pulses += more;
    end
    check("single_extra_pulses", 32'(pulses), 32'h0);

    // Hold for 80 ticks in ADJ(2); record the tick index behind each INC.
`ifdef CLKADJ_AUTOREPEAT_EN
    exp_q.push_back(16'd50);
    exp_q.push_back(16'd60);
    exp_q.push_back(16'd70);
    exp_q.push_back(16'd80);
`endif
    bus.ADJUST = 1'b1;
    cycle();
    check("repeat_press_inc", 32'(bus.INC), 32'h4);
    for (int t = 1; t <= 80; t++) begin
      bus.tick = 1'b1;
      cycle();
      if (bus.INC != 3'b000) obs_q.push_back((bus.INC == 3'b100) ? 16'(t) : 16'hffff);
      bus.tick = 1'b0;
      cycle();
      if (bus.INC != 3'b000) obs_q.push_back(16'hfffe);
    end
    check("repeat_count", 32'(obs_q.size()), 32'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      check("repeat_tick", 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    end
    bus.ADJUST = 1'b0;
    cycle();
    check("repeat_still_adj", 32'(bus.ADJMODE), 32'h1);
    pulse_mode();

    // Inactivity timeout: ADJMODE drops one cycle after the TIMEOUT-th tick.
    do_reset();
    pulse_mode();
    check("to_enter", 32'(bus.ADJMODE), 32'h1);
    run_ticks(TIMEOUT - 1, pulses);
    check("to_before", 32'(bus.ADJMODE), 32'h1);
    bus.tick = 1'b1;
    cycle();
    bus.tick = 1'b0;
    check("to_fire", 32'(bus.ADJMODE), 32'h0);
    check("to_field", 32'(bus.FIELD), 32'h0);
    cycle();

    // A press on tick TIMEOUT-1 restarts the count.
    pulse_mode();
    run_ticks(TIMEOUT - 2, pulses);
    bus.ADJUST = 1'b1;
    bus.tick   = 1'b1;
    cycle();
    check("to_press_inc", 32'(bus.INC), 32'h1);
    bus.ADJUST = 1'b0;
    bus.tick   = 1'b0;
    cycle();
    run_ticks(TIMEOUT - 1, pulses);
    check("to_restart_hold", 32'(bus.ADJMODE), 32'h1);
    bus.tick = 1'b1;
    cycle();
    bus.tick = 1'b0;
    check("to_restart_fire", 32'(bus.ADJMODE), 32'h0);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
